// File: rtl/sevseg_pkg.sv
// -----------------------------------------------------------------------------
// sevseg_pkg
//   Shared constants for the seven-segment display driver.
//   - SEG_A..SEG_G : bit positions of each segment inside a 7-bit segment word
//   - SEG_OFF      : segment word with every segment dark (active-high form)
//   - HEX_SEG_TABLE: active-high segment pattern for each hex digit 0..F
//   - hex_to_seg() : table lookup helper
// -----------------------------------------------------------------------------
package sevseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  // Bit 0 = A ... bit 6 = G, 1 = lit.
  localparam seg_t HEX_SEG_TABLE [16] = '{
    7'h3F,  // 0 ABCDEF
    7'h06,  // 1 BC
    7'h5B,  // 2 ABDEG
    7'h4F,  // 3 ABCDG
    7'h66,  // 4 BCFG
    7'h6D,  // 5 ACDFG
    7'h7D,  // 6 ACDEFG
    7'h07,  // 7 ABC
    7'h7F,  // 8 ABCDEFG
    7'h6F,  // 9 ABCDFG
    7'h77,  // A ABCEFG
    7'h7C,  // b CDEFG
    7'h39,  // C ADEF
    7'h5E,  // d BCDEG
    7'h79,  // E ADEFG
    7'h71   // F AEFG
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_segment_mux_if.sv
// -----------------------------------------------------------------------------
// seven_segment_mux_if
//   Bundles the application-side and display-side signals of seven_segment_mux.
//   Parameter NUM_DIGITS must match the driver instance.
//   i_value  : 4*NUM_DIGITS packed nibbles, nibble k = digit k (digit 0 rightmost)
//   i_dp     : decimal point per digit, 1 = lit
//   i_load   : capture i_value/i_dp into the pending register
//   i_blank  : 1 = all digit enables inactive, scan keeps running
//   o_seg    : segments bit0=A..bit6=G (board polarity)
//   o_dp     : decimal point (board polarity)
//   o_dig_en : one-hot digit enable (board polarity)
//   o_frame  : 1-cycle pulse when pending value becomes active
//   master = application/testbench side, slave = driver side.
// -----------------------------------------------------------------------------
interface seven_segment_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] i_value;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic                    i_load;
  logic                    i_blank;
  logic [6:0]              o_seg;
  logic                    o_dp;
  logic [NUM_DIGITS-1:0]   o_dig_en;
  logic                    o_frame;

  modport master (
    output i_value, i_dp, i_load, i_blank,
    input  o_seg, o_dp, o_dig_en, o_frame
  );

  modport slave (
    input  i_value, i_dp, i_load, i_blank,
    output o_seg, o_dp, o_dig_en, o_frame
  );
endinterface

// File: rtl/seven_segment_decode.sv
// -----------------------------------------------------------------------------
// seven_segment_decode
//   Combinational hex nibble to active-high segment pattern.
//   i_nibble : 4-bit hex digit
//   o_seg    : segments bit0=A..bit6=G, 1 = lit
// -----------------------------------------------------------------------------
module seven_segment_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  always_comb begin
    o_seg = hex_to_seg(i_nibble);
  end

endmodule

// File: rtl/seven_segment_mux.sv
// -----------------------------------------------------------------------------
// seven_segment_mux
//   Time-multiplexed driver for a NUM_DIGITS seven-segment display. A value
//   loaded at any time is held in a pending register and only becomes visible
//   at a frame boundary, so a frame never mixes old and new digits. Each digit
//   slot starts with GUARD_CLKS clocks of all-enables-off to suppress ghosting.
//
//   Ports:
//     i_clk : system clock
//     i_rst : asynchronous active-high reset
//     bus   : seven_segment_mux_if.slave (value/dp/load/blank in,
//             seg/dp/dig_en/frame out, all outputs registered)
//
//   Optional feature: define SEVSEG_LZB_EN for leading-zero blanking. Digit k
//   (k >= 1) is blanked when nibbles k..NUM_DIGITS-1 are all zero; a blanked
//   digit with its dp set stays enabled with dark segments and the dp lit.
// -----------------------------------------------------------------------------
module seven_segment_mux
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int GUARD_CLKS     = 2,
  parameter int SEG_ACT_LOW    = 1,
  parameter int DIG_ACT_LOW    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  seven_segment_mux_if.slave bus
);

  localparam int TICK_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W  = 4 * NUM_DIGITS;

  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_IDLE  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_IDLE   = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE  = (DIG_ACT_LOW != 0) ? '1 : '0;

  logic [TICK_W-1:0]     tick_q,      tick_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic [VAL_W-1:0]      pend_val_q,  pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q,   pend_dp_d;
  logic [VAL_W-1:0]      act_val_q,   act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q,    act_dp_d;
  logic [6:0]            seg_q,       seg_d;
  logic                  dp_q,        dp_d;
  logic [NUM_DIGITS-1:0] dig_en_q,    dig_en_d;
  logic                  frame_q,     frame_d;

  logic                  tick_last;
  logic                  frame_edge;
  logic                  in_guard;
  logic                  show;
  logic [3:0]            cur_nibble;
  seg_t                  dec_seg;
  seg_t                  seg_lit;
  logic                  dp_lit;
  logic [NUM_DIGITS-1:0] digit_blanked;
  logic [NUM_DIGITS-1:0] dig_on;

  assign tick_last  = (tick_q == TICK_LAST);
  assign frame_edge = tick_last && (idx_q == IDX_LAST);
  assign in_guard   = int'(tick_q) < GUARD_CLKS;
  assign show       = !in_guard && !bus.i_blank;
  assign cur_nibble = act_val_q[{idx_q, 2'b00} +: 4];

  seven_segment_decode u_decode (
    .i_nibble (cur_nibble),
    .o_seg    (dec_seg)
  );

`ifdef SEVSEG_LZB_EN
  // Walk from the most significant digit down; a digit is blanked while every
  // nibble from it upward is zero. Digit 0 always shows.
  always_comb begin
    logic all_zero;
    digit_blanked = '0;
    all_zero      = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero         = all_zero && (act_val_q[4*k +: 4] == 4'h0);
      digit_blanked[k] = all_zero;
    end
  end
`else
  assign digit_blanked = '0;
`endif

  // A blanked digit keeps its enable only to show its decimal point.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    assign dig_on[gi] = show && (idx_q == IDX_W'(gi)) &&
                        (!digit_blanked[gi] || act_dp_q[gi]);
  end

  always_comb begin
    tick_d = tick_last ? '0 : tick_q + 1'b1;
    idx_d  = idx_q;
    if (tick_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    pend_val_d = bus.i_load ? bus.i_value : pend_val_q;
    pend_dp_d  = bus.i_load ? bus.i_dp    : pend_dp_q;

    // A load coinciding with the boundary goes straight to the display.
    act_val_d = act_val_q;
    act_dp_d  = act_dp_q;
    if (frame_edge) begin
      act_val_d = bus.i_load ? bus.i_value : pend_val_q;
      act_dp_d  = bus.i_load ? bus.i_dp    : pend_dp_q;
    end

    frame_d = frame_edge;

    // Active-high internally; board polarity applied just before the flops.
    seg_lit  = (in_guard || digit_blanked[idx_q]) ? SEG_OFF : dec_seg;
    dp_lit   = !in_guard && act_dp_q[idx_q];
    seg_d    = (SEG_ACT_LOW != 0) ? ~seg_lit : seg_lit;
    dp_d     = (SEG_ACT_LOW != 0) ? ~dp_lit  : dp_lit;
    dig_en_d = (DIG_ACT_LOW != 0) ? ~dig_on  : dig_on;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_q     <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      seg_q      <= SEG_IDLE;
      dp_q       <= DP_IDLE;
      dig_en_q   <= DIG_IDLE;
      frame_q    <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_en_q   <= dig_en_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.o_seg    = seg_q;
  assign bus.o_dp     = dp_q;
  assign bus.o_dig_en = dig_en_q;
  assign bus.o_frame  = frame_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_mux
//   Scoreboard bench for seven_segment_mux with NUM_DIGITS=4, CLKS_PER_DIGIT=8,
//   GUARD_CLKS=2, active-low segments and digit enables. Define SEVSEG_LZB_EN
//   for both DUT and bench to exercise leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_seven_segment_mux;

  localparam int ND  = 4;
  localparam int CPD = 8;
  localparam int GC  = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_mux_if #(.NUM_DIGITS(ND)) bus_if ();

  seven_segment_mux #(
    .NUM_DIGITS     (ND),
    .CLKS_PER_DIGIT (CPD),
    .GUARD_CLKS     (GC),
    .SEG_ACT_LOW    (1),
    .DIG_ACT_LOW    (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  int frames_seen = 0;

  // Reference model state (value before the next rising edge).
  int         m_tick = 0;
  int         m_idx  = 0;
  logic [15:0] m_pend_v  = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [15:0] m_act_v   = '0;
  logic [3:0]  m_act_dp  = '0;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Lit segments per hex digit, bit0=A .. bit6=G, written from the letter lists.
  function automatic logic [6:0] lit_segs(input logic [3:0] n);
    case (n)
      4'h0: lit_segs = 7'b0111111;
      4'h1: lit_segs = 7'b0000110;
      4'h2: lit_segs = 7'b1011011;
      4'h3: lit_segs = 7'b1001111;
      4'h4: lit_segs = 7'b1100110;
      4'h5: lit_segs = 7'b1101101;
      4'h6: lit_segs = 7'b1111101;
      4'h7: lit_segs = 7'b0000111;
      4'h8: lit_segs = 7'b1111111;
      4'h9: lit_segs = 7'b1101111;
      4'hA: lit_segs = 7'b1110111;
      4'hB: lit_segs = 7'b1111100;
      4'hC: lit_segs = 7'b0111001;
      4'hD: lit_segs = 7'b1011110;
      4'hE: lit_segs = 7'b1111001;
      default: lit_segs = 7'b1110001;
    endcase
  endfunction

  function automatic logic lz_blank(input int k, input logic [15:0] v);
`ifdef SEVSEG_LZB_EN
    return (k >= 1) && ((v >> (4 * k)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Predict next registered outputs from model state and current inputs,
  // advance the model, clock the DUT and compare.
  task automatic cycle();
    exp_t       e;
    exp_t       got_e;
    logic       guard;
    logic       blk;
    logic       dpb;
    logic [3:0] nib;
    guard = (m_tick < GC);
    blk   = lz_blank(m_idx, m_act_v);
    dpb   = m_act_dp[m_idx];
    nib   = m_act_v[4*m_idx +: 4];
    e.dig = 4'hF;
    if (!guard && !bus_if.i_blank && (!blk || dpb)) e.dig[m_idx] = 1'b0;
    e.seg   = (guard || blk) ? 7'h7F : ~lit_segs(nib);
    e.dp    = guard ? 1'b1 : ~dpb;
    e.frame = (m_tick == CPD - 1) && (m_idx == ND - 1);
    sb_q.push_back(e);

    if (e.frame) begin
      m_act_v  = bus_if.i_load ? bus_if.i_value : m_pend_v;
      m_act_dp = bus_if.i_load ? bus_if.i_dp    : m_pend_dp;
    end
    if (bus_if.i_load) begin
      m_pend_v  = bus_if.i_value;
      m_pend_dp = bus_if.i_dp;
    end
    if (m_tick == CPD - 1) begin
      m_tick = 0;
      m_idx  = (m_idx + 1) % ND;
    end else begin
      m_tick++;
    end

    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    chk("seg",    bus_if.o_seg,    got_e.seg);
    chk("dp",     bus_if.o_dp,     got_e.dp);
    chk("dig_en", bus_if.o_dig_en, got_e.dig);
    chk("frame",  bus_if.o_frame,  got_e.frame);
    if (bus_if.o_frame) frames_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] dp);
    $display("load value=%04h dp=%01h tick=%0d idx=%0d", v, dp, m_tick, m_idx);
    bus_if.i_value = v;
    bus_if.i_dp    = dp;
    bus_if.i_load  = 1'b1;
    cycle();
    bus_if.i_load  = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_seg"},   bus_if.o_seg,    7'h7F);
    chk({tag, "_dp"},    bus_if.o_dp,     1'b1);
    chk({tag, "_dig"},   bus_if.o_dig_en, 4'hF);
    chk({tag, "_frame"}, bus_if.o_frame,  1'b0);
  endtask

  task automatic model_reset();
    m_tick = 0; m_idx = 0;
    m_pend_v = '0; m_pend_dp = '0;
    m_act_v  = '0; m_act_dp  = '0;
  endtask

  initial begin
    bus_if.i_value = '0;
    bus_if.i_dp    = '0;
    bus_if.i_load  = 1'b0;
    bus_if.i_blank = 1'b0;

    // 1. Reset held then released; scan order and frame cadence.
    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    rst = 1'b0;
    model_reset();
    frames_seen = 0;
    run(64);
    chk("frame_cnt_64", frames_seen, 2);

    // 2. Load 1A3F, let it reach the display.
    load_once(16'h1A3F, 4'h0);
    run(70);

    // 3. Mid-frame load of zero, then a load exactly on the boundary cycle.
    while (m_tick != 3 || m_idx != 1) cycle();
    load_once(16'h0000, 4'h0);
    run(20);
    while (!(m_tick == CPD - 1 && m_idx == ND - 1)) cycle();
    load_once(16'h2345, 4'h2);
    run(34);

    // 4. Blank for 40 clocks, release mid-slot.
    $display("blank on tick=%0d idx=%0d", m_tick, m_idx);
    bus_if.i_blank = 1'b1;
    frames_seen = 0;
    run(40);
    bus_if.i_blank = 1'b0;
    $display("blank off tick=%0d idx=%0d", m_tick, m_idx);
    run(24);
    chk("frame_cnt_blank", frames_seen, 2);

    // 5. Leading zeros with dp on the top digit.
    load_once(16'h0070, 4'h8);
    run(70);

    // 6. Asynchronous reset pulse mid-slot, away from the clock edge.
    while (m_tick != 4) cycle();
    #2;
    rst = 1'b1;
    #1;
    check_idle("arst");
    @(posedge clk);
    #1;
    check_idle("arst_hold");
    rst = 1'b0;
    $display("reset pulse released");
    model_reset();
    run(40);

    // Random loads and blanking.
    for (int i = 0; i < 160; i++) begin
      bus_if.i_blank = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) begin
        load_once(16'($urandom), 4'($urandom));
      end else begin
        cycle();
      end
    end
    bus_if.i_blank = 1'b0;
    run(8);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
